// File: rtl/sub_add_flag_unit.sv
// Registered ripple-carry add/subtract slice with N/Z/V/C flags.
// Define GATE_DELAY_EN to give every primitive gate a 50 ps delay.
`timescale 1ps/1ps

`ifdef GATE_DELAY_EN
`define SAFU_DLY #50
`else
`define SAFU_DLY
`endif

module sub_add_flag_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    wire [WIDTH-1:0] w_b_eff;
    wire [WIDTH-1:0] w_s;
    wire [WIDTH:0]   w_c;
    wire             w_any;
    wire             w_zero;
    wire             w_ovf;

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_neg;
    logic             r_zero;
    logic             r_ovf;
    logic             r_carry;

    // Subtract is a + ~b + 1: the carry-in supplies the +1.
    assign w_c[0] = sub;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            xor `SAFU_DLY g_binv (w_b_eff[i], b[i], sub);
            sub_add_fa u_fa (
                .i_a  (a[i]),
                .i_b  (w_b_eff[i]),
                .i_c  (w_c[i]),
                .o_s  (w_s[i]),
                .o_co (w_c[i+1])
            );
        end
    endgenerate

    sub_add_or_tree #(.N(WIDTH)) u_zt (
        .i_x   (w_s),
        .o_any (w_any)
    );

    not `SAFU_DLY g_nz  (w_zero, w_any);
    xor `SAFU_DLY g_ovf (w_ovf, w_c[WIDTH-1], w_c[WIDTH]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_result <= w_s;
                r_neg    <= w_s[WIDTH-1];
                r_zero   <= w_zero;
                r_ovf    <= w_ovf;
                r_carry  <= w_c[WIDTH];
            end
        end
    end

    assign valid_out = r_valid;
    assign result    = r_result;
    assign negative  = r_neg;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign carry_out = r_carry;

endmodule

module sub_add_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    wire w_p;
    wire w_g;
    wire w_t;

    // Majority via generate/propagate: ab | (a^b)c.
    xor `SAFU_DLY g_x1 (w_p, i_a, i_b);
    xor `SAFU_DLY g_x2 (o_s, w_p, i_c);
    and `SAFU_DLY g_a1 (w_g, i_a, i_b);
    and `SAFU_DLY g_a2 (w_t, w_p, i_c);
    or  `SAFU_DLY g_o1 (o_co, w_g, w_t);

endmodule

module sub_add_or_tree #(
    parameter int N = 64
) (
    input  logic [N-1:0] i_x,
    output logic         o_any
);

    genvar k;
    generate
        if (N == 1) begin : g_n1
            buf `SAFU_DLY g_b (o_any, i_x[0]);
        end else if (N == 2) begin : g_n2
            or `SAFU_DLY g_o (o_any, i_x[0], i_x[1]);
        end else if (N == 3) begin : g_n3
            or `SAFU_DLY g_o (o_any, i_x[0], i_x[1], i_x[2]);
        end else if (N == 4) begin : g_n4
            or `SAFU_DLY g_o (o_any, i_x[0], i_x[1],
                              i_x[2], i_x[3]);
        end else begin : g_split
            localparam int Q = N / 4;
            localparam int R = N % 4;
            wire [3:0] w_part;
            // Four near-equal slices keep the tree balanced.
            for (k = 0; k < 4; k++) begin : g_sub
                localparam int SZ  = Q + ((k < R) ? 1 : 0);
                localparam int OFF = k * Q + ((k < R) ? k : R);
                sub_add_or_tree #(.N(SZ)) u_sub (
                    .i_x   (i_x[OFF +: SZ]),
                    .o_any (w_part[k])
                );
            end
            or `SAFU_DLY g_o (o_any, w_part[0], w_part[1],
                              w_part[2], w_part[3]);
        end
    endgenerate

endmodule

`undef SAFU_DLY

// File: tb/tb_sub_add_flag_unit.sv
// Directed and random checks for sub_add_flag_unit.
// Uses a 20 ns clock so the gate-delay build also settles.
`timescale 1ps/1ps

module tb_sub_add_flag_unit;

    localparam int W = 64;

    typedef struct {
        string        name;
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         n;
        logic         z;
        logic         v;
        logic         c;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_in = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         valid_out;
    logic [W-1:0] result;
    logic         negative;
    logic         zero;
    logic         overflow;
    logic         carry_out;

    int total = 0;
    int bad = 0;

    vec_t vecs[9];

    sub_add_flag_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .valid_out (valid_out),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #10000 clk = ~clk;

    task automatic check(input string nm, input logic ev,
                         input logic [W-1:0] er, input logic en,
                         input logic ez, input logic eo,
                         input logic ec);
        total++;
        if ({valid_out, result, negative, zero, overflow,
             carry_out} !== {ev, er, en, ez, eo, ec}) begin
            bad++;
            $display("FAIL %s: got vo=%b r=%h n=%b z=%b v=%b c=%b want vo=%b r=%h n=%b z=%b v=%b c=%b",
                     nm, valid_out, result, negative, zero,
                     overflow, carry_out, ev, er, en, ez, eo, ec);
        end
    endtask

    task automatic step(input logic v, input logic s,
                        input logic [W-1:0] aa,
                        input logic [W-1:0] bb);
        @(negedge clk);
        valid_in = v;
        sub = s;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] msb;
        ones = '1;
        msb = '0;
        msb[W-1] = 1'b1;

        vecs[0] = '{"eq_sub", 1'b1, 64'd5, 64'd5,
                    64'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{"zero_minus_one", 1'b1, 64'd0, 64'd1,
                    ones, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"maxpos_plus_one", 1'b0, ~msb, 64'd1,
                    msb, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"ones_plus_one", 1'b0, ones, 64'd1,
                    64'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{"minneg_minus_one", 1'b1, msb, 64'd1,
                    ~msb, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{"zero_plus_zero", 1'b0, 64'd0, 64'd0,
                    64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{"minneg_plus_minneg", 1'b0, msb, msb,
                    64'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{"small_sub", 1'b1, 64'd3, 64'd10,
                    64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0,
                    1'b0, 1'b0};
        vecs[8] = '{"mixed_add", 1'b0, 64'h1234_5678_9ABC_DEF0,
                    64'h0FED_CBA9_8765_4321,
                    64'h2222_2222_2222_2211, 1'b0, 1'b0,
                    1'b0, 1'b0};

        // Reset held while a valid request is presented.
        valid_in = 1'b1;
        sub = 1'b0;
        a = 64'h1111;
        b = 64'h2222;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        valid_in = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step(1'b1, vecs[i].sub, vecs[i].a, vecs[i].b);
            check(vecs[i].name, 1'b1, vecs[i].r, vecs[i].n,
                  vecs[i].z, vecs[i].v, vecs[i].c);
        end

        // Back-to-back requests, then hold.
        step(1'b1, 1'b0, 64'd10, 64'd3);
        check("b2b_0", 1'b1, 64'd13, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'd10, 64'd3);
        check("b2b_1", 1'b1, 64'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 64'd3, 64'd10);
        check("b2b_2", 1'b1, 64'hFFFF_FFFF_FFFF_FFF9,
              1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 64'd1, 64'd1);
        check("hold_0", 1'b0, 64'hFFFF_FFFF_FFFF_FFF9,
              1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 64'd0, 64'd0);
        check("hold_1", 1'b0, 64'hFFFF_FFFF_FFFF_FFF9,
              1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges, mid-stream.
        step(1'b1, 1'b0, ones, 64'd1);
        #3000;
        reset = 1'b1;
        #1000;
        check("async_reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        valid_in = 1'b0;
        step(1'b0, 1'b0, 64'd9, 64'd9);
        check("post_reset_idle", 1'b0, '0, 1'b0, 1'b0,
              1'b0, 1'b0);
        step(1'b1, 1'b0, 64'd1, 64'd1);
        check("post_reset_first", 1'b1, 64'd2, 1'b0, 1'b0,
              1'b0, 1'b0);

        // Random vectors against a behavioural a +/- b model.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            logic [W:0]   wide;
            logic [W-1:0] er;
            logic         eo;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 7 == 0) rb = ra;
            rs = 1'($urandom_range(0, 1));
            if (rs)
                wide = {1'b0, ra} + {1'b0, ~rb} + 65'd1;
            else
                wide = {1'b0, ra} + {1'b0, rb};
            er = wide[W-1:0];
            if (rs)
                eo = (ra[W-1] != rb[W-1]) && (er[W-1] != ra[W-1]);
            else
                eo = (ra[W-1] == rb[W-1]) && (er[W-1] != ra[W-1]);
            step(1'b1, rs, ra, rb);
            check("random", 1'b1, er, er[W-1], er == '0,
                  eo, wide[W]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_add_flag_unit.md
Name: sub_add_flag_unit

Overview:
- Registered 64-bit two's-complement add/subtract datapath that produces ALU condition flags (negative, zero, overflow, carry).
- Built structurally from a chain of 1-bit full-adder cells (ripple carry) and a wide OR-reduction zero detector.
- Sits in the execute stage as the arithmetic/flag-generation slice of the ALU.
- Result and flags are captured in an output register one cycle after a valid request.

Parameters:
- WIDTH, 64, operand/result width in bits; must be ≥ 2.

Ports:
- clk      input   1      rising-edge clock
- reset    input   1      asynchronous, active-high reset
- valid_in input   1      request strobe; operands sampled when high
- sub      input   1      0 = A+B, 1 = A−B
- a        input   WIDTH  operand A
- b        input   WIDTH  operand B
- valid_out output 1      high for one cycle when result/flags are updated
- result   output  WIDTH  registered sum/difference
- negative output  1      registered result[WIDTH-1]
- zero     output  1      registered (result == 0)
- overflow output  1      registered signed overflow
- carry_out output 1      registered carry out of the MSB

Behaviour:
- Single clock domain; reset is asynchronous and active-high.
- While reset is high:
  - result = 0
  - negative = 0, zero = 0, overflow = 0, carry_out = 0, valid_out = 0
  - zero is deliberately 0 after reset, even though result is 0.
- Datapath (combinational):
  - b_eff = sub ? ~b : b; carry into bit 0 = sub.
  - Per-bit full adder: s[i] = a[i]^b_eff[i]^c[i]; c[i+1] = majority(a[i], b_eff[i], c[i]).
  - c[0] = sub.
- Flags, computed from the combinational sum:
  - negative = s[WIDTH-1]
  - carry_out = c[WIDTH]; for subtract this is 1 when there is no borrow (a ≥ b unsigned).
  - overflow = c[WIDTH-1] ^ c[WIDTH]
  - zero = NOR of all s bits, implemented as a balanced reduction tree of at most 4-input gates.
- Latency and register update:
  - On a rising clk edge with valid_in = 1, result and all four flags load the combinational values and valid_out = 1 on the following cycle.
  - With valid_in = 0 at the edge, result and flags hold their previous values and valid_out = 0.
- No handshake backpressure: one new operation can be accepted every cycle, and back-to-back requests each produce their own valid_out pulse.
- Boundary conditions:
  - a = b with sub = 1 → result 0, zero 1, carry_out 1.
  - Most-negative minus 1 → overflow 1.
  - All-ones + 1 → result 0, carry_out 1, zero 1, overflow 0.
- If reset asserts mid-stream, outputs clear immediately. The first valid_out after reset deassertion is for the first valid_in sampled after deassertion.

Optional Feature:
- Macro GATE_DELAY_EN.
- When defined:
  - Every primitive gate in the full-adder cells, the b inverters, the flag logic and the zero tree carries a 50 ps propagation delay (timescale 1ps/1ps).
  - Clock period must exceed the worst-case ripple plus zero-tree delay; the bench uses 20 ns.
- When undefined: all combinational logic is zero-delay and behaviour is purely functional.
- Register behaviour is identical in both builds.

Test Plan:
- Reset asserted with nonzero a/b and valid_in = 1 → all outputs 0, valid_out 0; release, then 5−5 (sub=1) → next cycle result 0, zero 1, carry_out 1, negative 0, overflow 0, valid_out 1.
- sub=1, a=0, b=1 → result 0xFFFF_FFFF_FFFF_FFFF, negative 1, carry_out 0, zero 0, overflow 0.
- sub=0, a=0x7FFF_FFFF_FFFF_FFFF, b=1 → result 0x8000_0000_0000_0000, overflow 1, negative 1, carry_out 0.
- sub=0, a=all-ones, b=1 → result 0, zero 1, carry_out 1, overflow 0; sub=1, a=0x8000_0000_0000_0000, b=1 → overflow 1, negative 0.
- Back-to-back valid_in for 3 cycles (10+3, 10−3, 3−10), then valid_in low → results 13, 7, 0xFFFF_FFFF_FFFF_FFF9 on consecutive cycles with valid_out high; outputs then hold with valid_out 0.
- Reset pulsed asynchronously between clock edges mid-stream → outputs clear without a clock edge; 1000 random a/b/sub vectors match a behavioural a±b model (rerun with GATE_DELAY_EN, 20 ns clock).
